// File: rtl/addc_sched_pkg.sv
// Shared definitions for the ADDC scheduler: datapath widths, FSM states
// and a small wrap-around helper for the round-robin pointer.
package addc_sched_pkg;

  localparam int DQ_W  = 16;  // sign-magnitude quantized difference
  localparam int SEZ_W = 15;  // two's complement partial signal estimate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // Channel after ch, wrapping from n-1 back to 0.
  function automatic int next_ch(input int ch, input int n);
    return (ch + 1 >= n) ? 0 : ch + 1;
  endfunction

endpackage

// File: rtl/addc_sched_if.sv
// Bundle of request, operand, shared-ADDC and result signals between the
// scheduler (slave) and the surrounding channel/ADDC logic (master).
interface addc_sched_if
  import addc_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) ();

  // channel side
  logic [NCH-1:0]       req;
  logic [DQ_W*NCH-1:0]  dq_in;
  logic [SEZ_W*NCH-1:0] sez_in;
  logic [NCH-1:0]       ack;
  logic [NCH-1:0]       hist_clr;

  // shared ADDC unit
  logic [DQ_W-1:0]      addc_dq;
  logic [SEZ_W-1:0]     addc_sez;
  logic                 addc_pk0;
  logic                 addc_sigpk;

  // result handshake
  logic                 res_valid;
  logic                 res_ready;
  logic [CW-1:0]        res_ch;
  logic                 res_pk0;
  logic                 res_pk1;
  logic                 res_pk2;
  logic                 res_sigpk;
  logic                 busy;

  modport slave (
    input  req, dq_in, sez_in, hist_clr, addc_pk0, addc_sigpk, res_ready,
    output ack, addc_dq, addc_sez, res_valid, res_ch,
           res_pk0, res_pk1, res_pk2, res_sigpk, busy
  );

  modport master (
    output req, dq_in, sez_in, hist_clr, addc_pk0, addc_sigpk, res_ready,
    input  ack, addc_dq, addc_sez, res_valid, res_ch,
           res_pk0, res_pk1, res_pk2, res_sigpk, busy
  );

endinterface

// File: rtl/addc_sched_rr_arb.sv
// Combinational round-robin selector: first set request at or above the
// pointer, wrapping from the top channel back to channel 0.
module addc_sched_rr_arb #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CW-1:0]  ptr_i,
  output logic [NCH-1:0] grant_o,
  output logic [CW-1:0]  idx_o,
  output logic           any_o
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [CW-1:0]    off;
  logic [CW:0]      sum;

  // Rotate so the pointer channel sits at bit 0; a plain priority search
  // on the rotated vector then gives the wrap-around order.
  assign dbl = {req_i, req_i};
  assign rot = NCH'(dbl >> ptr_i);

  // Lowest set bit of the rotated vector is the offset from the pointer.
  always_comb begin
    off   = '0;
    any_o = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = CW'(k);
        any_o = 1'b1;
      end
    end
  end

  // Undo the rotation: pointer + offset modulo NCH.
  assign sum   = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o = (sum >= (CW+1)'(NCH)) ? CW'(sum - (CW+1)'(NCH)) : CW'(sum);

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_grant
    assign grant_o[gi] = any_o && (idx_o == CW'(gi));
  end

endmodule

// File: rtl/addc_sched.sv
// Time-multiplexes one ADDC unit across NCH ADPCM channels: grant a channel,
// present its operands for one cycle, capture PK0/SIGPK with the channel's
// PK1/PK2 history, and hand the result out on a valid/ready handshake.
module addc_sched
  import addc_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic         clk,
  input  logic         rst_n,
  addc_sched_if.slave  bus
);

  state_e             state_q;
  logic [CW-1:0]      rr_q;
  logic [CW-1:0]      ch_q;
  logic [DQ_W-1:0]    op_dq_q;
  logic [SEZ_W-1:0]   op_sez_q;
  logic               res_valid_q;
  logic               pk0_q;
  logic               sigpk_q;
  logic               pk1_q;
  logic               pk2_q;
  logic               busy_q;
  logic               hist_pk1_q [NCH];
  logic               hist_pk2_q [NCH];

  logic [NCH-1:0]     grant;
  logic [CW-1:0]      g_idx;
  logic               g_any;
  logic [DQ_W-1:0]    dq_lane  [NCH];
  logic [SEZ_W-1:0]   sez_lane [NCH];

  addc_sched_rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
    .req_i   (bus.req),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (g_idx),
    .any_o   (g_any)
  );

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_lane
    assign dq_lane[gi]  = bus.dq_in[gi*DQ_W +: DQ_W];
    assign sez_lane[gi] = bus.sez_in[gi*SEZ_W +: SEZ_W];
  end

  // Scheduler FSM: grant in IDLE, sample the shared unit in EXEC, hold the
  // result in WB until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      ch_q        <= '0;
      op_dq_q     <= '0;
      op_sez_q    <= '0;
      res_valid_q <= 1'b0;
      pk0_q       <= 1'b0;
      sigpk_q     <= 1'b0;
      pk1_q       <= 1'b0;
      pk2_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (g_any) begin
            op_dq_q  <= dq_lane[g_idx];
            op_sez_q <= sez_lane[g_idx];
            ch_q     <= g_idx;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          pk0_q       <= bus.addc_pk0;
          sigpk_q     <= bus.addc_sigpk;
          pk1_q       <= hist_pk1_q[ch_q];
          pk2_q       <= hist_pk2_q[ch_q];
          res_valid_q <= 1'b1;
          state_q     <= WB;
        end
        WB: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            rr_q        <= CW'(next_ch(int'(ch_q), NCH));
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel sign history; a clear overrides a coincident EXEC shift.
  for (gi = 0; gi < NCH; gi++) begin : g_hist
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hist_pk1_q[gi] <= 1'b0;
        hist_pk2_q[gi] <= 1'b0;
      end else if (bus.hist_clr[gi]) begin
        hist_pk1_q[gi] <= 1'b0;
        hist_pk2_q[gi] <= 1'b0;
      end else if (state_q == EXEC && ch_q == CW'(gi)) begin
        hist_pk2_q[gi] <= hist_pk1_q[gi];
        hist_pk1_q[gi] <= bus.addc_pk0;
      end
    end
  end

  // The grant is acknowledged in the same IDLE cycle it is decided, so the
  // requester's operands only need to be valid in that cycle.
  assign bus.ack       = (rst_n && state_q == IDLE) ? grant : '0;
  assign bus.addc_dq   = op_dq_q;
  assign bus.addc_sez  = op_sez_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = ch_q;
  assign bus.res_pk0   = pk0_q;
  assign bus.res_pk1   = pk1_q;
  assign bus.res_pk2   = pk2_q;
  assign bus.res_sigpk = sigpk_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_addc_sched.sv
// Bench for addc_sched: table of directed operations, hand-written sequences
// for history clear and mid-operation reset, then randomized traffic checked
// against an arithmetic reference model.
module tb_addc_sched;
  import addc_sched_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = $clog2(NCH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addc_sched_if #(.NCH(NCH)) bus ();

  addc_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ADDC unit, modelled in the hardware's own bit-level form.
  logic [15:0] m_dqi, m_sezi, m_sum;
  assign m_dqi  = bus.addc_dq[15] ? (16'd0 - {1'b0, bus.addc_dq[14:0]})
                                  : {1'b0, bus.addc_dq[14:0]};
  assign m_sezi = {bus.addc_sez[14], bus.addc_sez};
  assign m_sum  = m_dqi + m_sezi;
  assign bus.addc_pk0   = m_sum[15];
  assign bus.addc_sigpk = (m_sum == 16'd0);

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state for the randomized phase.
  int mh1 [NCH];
  int mh2 [NCH];
  int mptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed value of the sum, wrapped to 16 bits as the unit does.
  task automatic ref_sum(input logic [15:0] dq, input logic [14:0] sez,
                         output logic pk0, output logic sig);
    int a, b, s;
    a = int'(dq[14:0]);
    if (dq[15]) a = -a;
    b = sez[14] ? int'(sez) - 32768 : int'(sez);
    s = a + b;
    s = ((s % 65536) + 65536) % 65536;
    pk0 = (s >= 32768);
    sig = (s == 0);
  endtask

  function automatic int ref_pick(input logic [NCH-1:0] r);
    for (int k = 0; k < NCH; k++)
      if (r[(mptr + k) % NCH]) return (mptr + k) % NCH;
    return -1;
  endfunction

  task automatic do_reset();
    bus.req       = '0;
    bus.hist_clr  = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mptr = 0;
    for (int c = 0; c < NCH; c++) begin
      mh1[c] = 0;
      mh2[c] = 0;
    end
  endtask

  task automatic idle_checks(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk({tag, "_ack"},   32'(bus.ack), 0);
      chk({tag, "_valid"}, 32'(bus.res_valid), 0);
      chk({tag, "_busy"},  32'(bus.busy), 0);
    end
  endtask

  // Apply one operation (called just after a rising edge, DUT in IDLE) and
  // compare everything against the given expectations.
  task automatic run_op(input string tag,
                        input logic [NCH-1:0] reqv,
                        input logic [16*NCH-1:0] dq_all,
                        input logic [15*NCH-1:0] sez_all,
                        input int dly, input logic [NCH-1:0] clr,
                        input int ech, input logic epk0, input logic esig,
                        input logic epk1, input logic epk2);
    bus.req    = reqv;
    bus.dq_in  = dq_all;
    bus.sez_in = sez_all;
    @(negedge clk);
    chk({tag, "_ack"}, 32'(bus.ack), 32'(1) << ech);
    @(posedge clk);
    #1;
    bus.req = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.dq_in[c*16 +: 16]  = 16'($urandom);
      bus.sez_in[c*15 +: 15] = 15'($urandom);
    end
    bus.hist_clr = clr;
    @(negedge clk);
    chk({tag, "_exec_dq"},    32'(bus.addc_dq),  32'(dq_all[ech*16 +: 16]));
    chk({tag, "_exec_sez"},   32'(bus.addc_sez), 32'(sez_all[ech*15 +: 15]));
    chk({tag, "_exec_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_exec_busy"},  32'(bus.busy), 1);
    @(posedge clk);
    #1;
    bus.hist_clr = '0;
    for (int d = 0; d <= dly; d++) begin
      bus.res_ready = (d == dly);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(bus.res_valid), 1);
      chk({tag, "_ch"},    32'(bus.res_ch), 32'(ech));
      chk({tag, "_pk0"},   32'(bus.res_pk0), 32'(epk0));
      chk({tag, "_sigpk"}, 32'(bus.res_sigpk), 32'(esig));
      chk({tag, "_pk1"},   32'(bus.res_pk1), 32'(epk1));
      chk({tag, "_pk2"},   32'(bus.res_pk2), 32'(epk2));
      chk({tag, "_wb_ack"}, 32'(bus.ack), 0);
      @(posedge clk);
      #1;
    end
    bus.res_ready = 1'b0;
    $display("[TB] op %s req=%b ch=%0d pk0=%0d sigpk=%0d pk1=%0d pk2=%0d stall=%0d",
             tag, reqv, bus.res_ch, bus.res_pk0, bus.res_sigpk, bus.res_pk1,
             bus.res_pk2, dly);
  endtask

  typedef struct {
    logic             pre_rst;
    logic [NCH-1:0]   req;
    logic [15:0]      dq;
    logic [14:0]      sez;
    int               dly;
    int               ch;
    logic             pk0;
    logic             sig;
    logic             pk1;
    logic             pk2;
  } vec_t;

  vec_t vt [12];

  // Build lanes with random content except the expected channel's lane.
  task automatic run_vec(input string tag, input vec_t v);
    logic [16*NCH-1:0] dq_all;
    logic [15*NCH-1:0] sez_all;
    for (int c = 0; c < NCH; c++) begin
      dq_all[c*16 +: 16]  = 16'($urandom);
      sez_all[c*15 +: 15] = 15'($urandom);
    end
    dq_all[v.ch*16 +: 16]  = v.dq;
    sez_all[v.ch*15 +: 15] = v.sez;
    run_op(tag, v.req, dq_all, sez_all, v.dly, '0, v.ch, v.pk0, v.sig, v.pk1, v.pk2);
  endtask

  initial begin
    logic [16*NCH-1:0] dq_all;
    logic [15*NCH-1:0] sez_all;
    logic [NCH-1:0]    reqv, clr;
    logic              e0, es;
    int                g, dly;

    bus.req = '0; bus.dq_in = '0; bus.sez_in = '0;
    bus.hist_clr = '0; bus.res_ready = 1'b0;

    //             rst   req      dq        sez     dly ch pk0 sig pk1 pk2
    vt[0]  = '{1'b0, 4'b0001, 16'h8005, 15'h0005, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 4'b0010, 16'h8004, 15'h0001, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 4'b0010, 16'h0003, 15'h7FFE, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 4'b0010, 16'h0000, 15'h0000, 0, 1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 4'b1111, 16'h8001, 15'h0000, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 4'b1111, 16'h0010, 15'h7FF0, 5, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 4'b1111, 16'h7FFF, 15'h0001, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 4'b1111, 16'hFFFF, 15'h4000, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 4'b1001, 16'h0000, 15'h0000, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 4'b1001, 16'h8000, 15'h0000, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 4'b1001, 16'h0005, 15'h7FF0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b0, 4'b1001, 16'h0001, 15'h3FFF, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset and idle behaviour.
    do_reset();
    @(negedge clk);
    chk("rst_dq",  32'(bus.addc_dq), 0);
    chk("rst_sez", 32'(bus.addc_sez), 0);
    chk("rst_res", 32'({bus.res_ch, bus.res_pk0, bus.res_pk1, bus.res_pk2, bus.res_sigpk}), 0);
    idle_checks("rst_idle", 10);
    @(posedge clk);
    #1;

    // Directed table: zero sum, history shift, fairness, backpressure.
    for (int i = 0; i < 12; i++) begin
      if (vt[i].pre_rst) begin
        do_reset();
        @(posedge clk);
        #1;
      end
      run_vec($sformatf("vec%0d", i), vt[i]);
    end

    // History clear in channel 2's EXEC cycle: result reports pre-clear
    // history, next channel-2 result sees zeros.
    dq_all = '0; sez_all = '0;
    dq_all[2*16 +: 16] = 16'h0001;
    run_op("clr_a", 4'b0100, dq_all, sez_all, 0, 4'b0100, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    dq_all[2*16 +: 16] = 16'h8001;
    run_op("clr_b", 4'b0100, dq_all, sez_all, 0, 4'b0000, 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while channel 2 is in EXEC.
    bus.req = 4'b0100;
    bus.dq_in = '0;
    bus.dq_in[2*16 +: 16] = 16'h8001;
    bus.sez_in = '0;
    @(negedge clk);
    chk("mid_ack", 32'(bus.ack), 32'h4);
    @(posedge clk);
    #1;
    bus.req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_checks("mid_after", 10);
    @(posedge clk);
    #1;
    dq_all = '0;
    run_op("mid_hist", 4'b0100, dq_all, sez_all, 0, '0, 2, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    @(posedge clk);
    #1;
    for (int n = 0; n < 60; n++) begin
      reqv = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int c = 0; c < NCH; c++) begin
        dq_all[c*16 +: 16]  = 16'($urandom);
        sez_all[c*15 +: 15] = 15'($urandom);
      end
      dly = $urandom_range(0, 2);
      clr = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      g = ref_pick(reqv);
      ref_sum(dq_all[g*16 +: 16], sez_all[g*15 +: 15], e0, es);
      run_op($sformatf("rnd%0d", n), reqv, dq_all, sez_all, dly, clr, g, e0, es,
             mh1[g][0], mh2[g][0]);
      mh2[g] = mh1[g];
      mh1[g] = int'(e0);
      for (int c = 0; c < NCH; c++) begin
        if (clr[c]) begin
          mh1[c] = 0;
          mh2[c] = 0;
        end
      end
      mptr = (g + 1) % NCH;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
